minterm_enumerator: RTL and testbench
=====================================

MINTERM_ENUMERATOR -- requirements
Module: minterm_enumerator

Interface
REQ-001 SHALL have parameter N, default 3, number of function inputs (table width 2^N).
REQ-002 SHALL have parameter DEFAULT_TABLE, default 8'hD5, truth table with bit i = f(i), so minterms are 0,2,4,6,7.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin one enumeration pass; sampled only in IDLE.
REQ-006 SHALL have port table_in  input  2^N  truth table to enumerate, bit i = f(i).
REQ-007 SHALL have port use_default  input  1  when 1, load DEFAULT_TABLE instead of table_in.
REQ-008 SHALL have port maxterm_mode  input  1  when 1, enumerate zeros (maxterms) by inverting the loaded table.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port m_valid  output  1  m_index holds a valid term.
REQ-011 SHALL have port m_ready  input  1  consumer accepts the term.
REQ-012 SHALL have port m_index  output  N  term index being offered.
REQ-013 SHALL have port m_last  output  1  offered term is the final term of this pass.
REQ-014 SHALL have port done  output  1  one-cycle pulse at end of pass.
REQ-015 SHALL have port count  output  N+1  number of terms accepted in the last or current pass.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN, EMIT, DONE.
REQ-017 IDLE with start=1 SHALL perform all of the following, then enter SCAN next cycle:
- latch table: DEFAULT_TABLE if use_default, else table_in;
- bitwise-invert the latched table if maxterm_mode;
- set idx=0 and count=0.
REQ-018 start, table_in, use_default and maxterm_mode SHALL be ignored outside IDLE; the latched table is frozen for the pass.
REQ-019 SCAN SHALL examine one index per cycle, with the following transitions:
- bit[idx]=1: go to EMIT;
- bit[idx]=0 and idx=2^N-1: go to DONE;
- otherwise: increment idx and stay in SCAN.
REQ-020 EMIT SHALL drive m_valid=1 and m_index=idx, and SHALL drive m_last=1 iff no latched bit above idx is set.
REQ-021 m_valid, m_index and m_last SHALL hold stable while m_ready=0; no term is skipped or duplicated.
REQ-022 A handshake (m_valid & m_ready) SHALL have the following effects:
- increment count;
- if idx=2^N-1 or m_last=1, go to DONE;
- otherwise increment idx and go to SCAN.
REQ-023 m_valid SHALL be 0 in all states other than EMIT, and m_index/m_last SHALL be 0 when m_valid=0.
REQ-024 DONE SHALL assert done for exactly one cycle and then return to IDLE; count SHALL hold until the next accepted start.
REQ-025 An all-zero latched table SHALL produce no m_valid, and done SHALL occur 2^N SCAN cycles after start (count=0).
REQ-026 An all-ones table SHALL emit every index 0..2^N-1 in ascending order (count=2^N, no overflow given width N+1).
REQ-027 idx SHALL never wrap past 2^N-1 within a pass.
REQ-028 Latency: a term at index k with no set bits below k SHALL present m_valid k+2 cycles after the start cycle, given m_ready=1 throughout.

Reset
REQ-029 rst=1 SHALL, on the next clock edge and regardless of state (including mid-EMIT), force:
- state IDLE;
- idx=0, count=0, latched table=0;
- busy=0, m_valid=0, m_index=0, m_last=0, done=0.
REQ-030 rst SHALL take priority over start and over a simultaneous handshake; the aborted pass produces no done pulse.

Verification
REQ-031 Bench SHALL cover: use_default=1, maxterm_mode=0, m_ready=1 -> m_index sequence 0,2,4,6,7, m_last only with 7, done pulse, count=5.
REQ-032 Bench SHALL cover: use_default=1, maxterm_mode=1 -> sequence 1,3,5, m_last with 5, count=3.
REQ-033 Bench SHALL cover: table_in=8'h00 -> no m_valid, done 9 cycles after start, count=0; table_in=8'hFF -> 0..7, count=8.
REQ-034 Bench SHALL cover: default table with m_ready low for 3 cycles while m_index=2 -> m_index held at 2, m_valid held high, then sequence continues 4,6,7 with count=5.
REQ-035 Bench SHALL cover: rst asserted while m_valid=1 at index 4 -> next cycle busy=0, m_valid=0, count=0, no done pulse; a new start then enumerates correctly from 0.
REQ-036 Bench SHALL cover: start pulsed with table_in=8'h0F while busy on the default table -> ignored, pass completes with count=5.

Source files
------------

// File: rtl/minterm_enumerator.sv
// Minterm/maxterm enumerator: walks a latched truth table in ascending index
// order and offers each set index on a valid/ready stream, then pulses done.
module minterm_enumerator #(
  parameter int unsigned         N             = 3,
  parameter logic [(2**N)-1:0]   DEFAULT_TABLE = 8'hD5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [(2**N)-1:0]    table_in,
  input  logic                 use_default,
  input  logic                 maxterm_mode,
  output logic                 busy,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [N-1:0]         m_index,
  output logic                 m_last,
  output logic                 done,
  output logic [N:0]           count
);

  localparam int unsigned TW      = 2**N;
  localparam int unsigned CW      = N + 1;
  localparam logic [N-1:0] IDX_MAX = N'(TW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [N-1:0]    idx, idx_n;
  logic [CW-1:0]   count_n;
  logic [TW-1:0]   tbl, tbl_n;

  logic            busy_n;
  logic            m_valid_n;
  logic [N-1:0]    m_index_n;
  logic            m_last_n;
  logic            done_n;

  // True when any table bit strictly above position k is set.
  function automatic logic has_above(input logic [TW-1:0] t, input logic [N-1:0] k);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < TW; i++) begin
      if (i > 32'(k)) r = r | t[i];
    end
    return r;
  endfunction

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    count_n = count;
    tbl_n   = tbl;

    case (state)
      IDLE: begin
        if (start) begin
          tbl_n = use_default ? DEFAULT_TABLE : table_in;
          if (maxterm_mode) tbl_n = ~tbl_n;
          idx_n   = '0;
          count_n = '0;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (tbl[idx]) begin
          state_n = EMIT;
        end else if (idx == IDX_MAX) begin
          state_n = DONE;
        end else begin
          idx_n = idx + N'(1);
        end
      end
      EMIT: begin
        if (m_ready) begin
          count_n = count + CW'(1);
          if (idx == IDX_MAX || m_last) begin
            state_n = DONE;
          end else begin
            idx_n   = idx + N'(1);
            state_n = SCAN;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Outputs are registered from the state being entered, so they line up
    // with the state register and stay frozen while EMIT is stalled.
    busy_n    = (state_n != IDLE);
    done_n    = (state_n == DONE);
    m_valid_n = (state_n == EMIT);
    m_index_n = m_valid_n ? idx_n : '0;
    m_last_n  = m_valid_n & ~has_above(tbl_n, idx_n);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      count   <= '0;
      tbl     <= '0;
      busy    <= 1'b0;
      m_valid <= 1'b0;
      m_index <= '0;
      m_last  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      count   <= count_n;
      tbl     <= tbl_n;
      busy    <= busy_n;
      m_valid <= m_valid_n;
      m_index <= m_index_n;
      m_last  <= m_last_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_minterm_enumerator.sv
// Directed, table-driven bench for minterm_enumerator (N=3).
module tb_minterm_enumerator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] table_in = 8'h00;
  logic       use_default = 1'b0;
  logic       maxterm_mode = 1'b0;
  logic       busy;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [2:0] m_index;
  logic       m_last;
  logic       done;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  minterm_enumerator #(.N(3), .DEFAULT_TABLE(8'hD5)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .table_in     (table_in),
    .use_default  (use_default),
    .maxterm_mode (maxterm_mode),
    .busy         (busy),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_index      (m_index),
    .m_last       (m_last),
    .done         (done),
    .count        (count)
  );

  always #5 clk = ~clk;

  // One pass description: seq holds the expected indices, term j in nibble j.
  typedef struct {
    logic        use_def;
    logic        maxt;
    logic [7:0]  tbl;
    int          n;
    logic [31:0] seq;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Run one full pass; optionally stall at stall_idx for stall_n cycles and
  // pulse a foreign start at cycle poke_cyc (ignored because busy).
  task automatic run_pass(input vec_t v, input int stall_idx, input int stall_n,
                          input int poke_cyc);
    int  nacc;
    int  first_v;
    int  done_cyc;
    int  stalls;
    bit  prev_stall;
    bit  r;
    int  exp_idx;
    @(negedge clk);
    use_default  = v.use_def;
    maxterm_mode = v.maxt;
    table_in     = v.tbl;
    m_ready      = 1'b1;
    start        = 1'b1;
    nacc = 0; first_v = -1; done_cyc = -1; stalls = 0; prev_stall = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == poke_cyc) begin
        start       = 1'b1;
        table_in    = 8'h0F;
        use_default = 1'b0;
      end else begin
        start = 1'b0;
      end
      if (cyc == 1) check("busy_after_start", int'(busy), 1);
      if (prev_stall) begin
        check("hold_valid", int'(m_valid), 1);
        check("hold_index", int'(m_index), stall_idx);
      end
      r = 1'b1;
      if (m_valid && int'(m_index) == stall_idx && stalls < stall_n) begin
        r = 1'b0;
        stalls++;
      end
      prev_stall = !r;
      m_ready = r;
      if (m_valid && first_v < 0) first_v = cyc;
      if (m_valid && r) begin
        if (nacc < v.n) begin
          exp_idx = int'((v.seq >> (4 * nacc)) & 32'hF);
          check("term_index", int'(m_index), exp_idx);
          check("term_last", int'(m_last), (nacc == v.n - 1) ? 1 : 0);
        end
        nacc++;
      end
      if (!m_valid) check("idle_index_zero", int'(m_index) + int'(m_last), 0);
      if (done) begin
        done_cyc = cyc;
        check("count_at_done", int'(count), v.n);
        break;
      end
    end
    m_ready = 1'b1;
    check("done_seen", (done_cyc >= 0) ? 1 : 0, 1);
    check("term_count", nacc, v.n);
    if (v.n > 0) check("first_latency", first_v, int'(v.seq[3:0]) + 2);
    else         check("empty_done_latency", done_cyc, 9);
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("idle_busy", int'(busy), 0);
    check("count_hold", int'(count), v.n);
  endtask

  initial begin
    bit found;
    bit seen_done;

    vecs[0] = '{1'b1, 1'b0, 8'h00, 5, 32'h0007_6420};  // default minterms
    vecs[1] = '{1'b1, 1'b1, 8'h00, 3, 32'h0000_0531};  // default maxterms
    vecs[2] = '{1'b0, 1'b0, 8'h00, 0, 32'h0000_0000};  // empty table
    vecs[3] = '{1'b0, 1'b0, 8'hFF, 8, 32'h7654_3210};  // all ones
    vecs[4] = '{1'b0, 1'b0, 8'h80, 1, 32'h0000_0007};  // single top term
    vecs[5] = '{1'b0, 1'b1, 8'h00, 8, 32'h7654_3210};  // inverted empty
    vecs[6] = '{1'b0, 1'b0, 8'h01, 1, 32'h0000_0000};  // single bottom term

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(m_valid), 0);
    check("rst_index", int'(m_index), 0);
    check("rst_last", int'(m_last), 0);
    check("rst_done", int'(done), 0);
    check("rst_count", int'(count), 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_pass(vecs[i], -1, 0, -1);

    // Back-pressure on index 2 for three cycles
    run_pass(vecs[0], 2, 3, -1);

    // Foreign start while busy is ignored
    run_pass(vecs[0], -1, 0, 3);

    // Reset mid-EMIT at index 4 with a simultaneous handshake
    @(negedge clk);
    use_default = 1'b1; maxterm_mode = 1'b0; m_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      if (m_valid && m_index == 3'd4) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("rst_mid_found_idx4", int'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_valid", int'(m_valid), 0);
    check("rst_mid_index", int'(m_index), 0);
    check("rst_mid_count", int'(count), 0);
    check("rst_mid_done", int'(done), 0);
    seen_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1;
    end
    check("rst_mid_no_done", int'(seen_done), 0);
    run_pass(vecs[0], -1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
